// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store initiator for the 8-bit data RAM (optional LSU_BOUNDS_CHECK_EN adds fault)
module load_store_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_IDX_W = 3
`ifdef LSU_BOUNDS_CHECK_EN
  , parameter int MEM_DEPTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [ADDR_W-1:0]    req_base,
  input  logic [ADDR_W-1:0]    req_offset,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [REG_IDX_W-1:0] req_rd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 st_done,
  output logic                 busy
`ifdef LSU_BOUNDS_CHECK_EN
  , output logic               fault
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
  state_t state;
  logic [REG_IDX_W-1:0] rd_q;
  logic [ADDR_W-1:0] ea;
  logic oob;
  assign ea = req_base + req_offset;
`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = {1'b0, ea} >= (ADDR_W+1)'(MEM_DEPTH);
`else
  assign oob = 1'b0;
`endif
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  // Request capture, one-cycle RAM access, then load write-back; mem_read doubles as "valid load in flight"
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_q <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      st_done <= 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
      fault <= 1'b0;
`endif
    end else begin
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      st_done <= 1'b0;
      wb_valid <= 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
      fault <= 1'b0;
`endif
      if (state == IDLE && req_valid) begin
        state <= ACCESS;
        mem_addr <= ea;
        rd_q <= req_rd;
        if (req_is_store) mem_wdata <= req_wdata;
        mem_write <= req_is_store && !oob;
        st_done <= req_is_store && !oob;
        mem_read <= !req_is_store && !oob;
`ifdef LSU_BOUNDS_CHECK_EN
        fault <= oob;
`endif
      end else if (state == ACCESS) begin
        state <= mem_read ? WB : IDLE;
        if (mem_read) begin
          wb_data <= mem_rdata;
          wb_rd <= rd_q;
          wb_valid <= 1'b1;
        end
      end else if (state == WB) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector bench with a behavioural 256x8 RAM
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_is_store = 1'b0;
  logic [7:0] req_base = '0, req_offset = '0, req_wdata = '0;
  logic [2:0] req_rd = '0;
  logic req_ready, mem_read, mem_write, wb_valid, st_done, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [2:0] wb_rd;
`ifdef LSU_BOUNDS_CHECK_EN
  logic fault;
`endif
  logic [7:0] ram [256];
  int checks = 0, errors = 0, overlap = 0, wb_pulses = 0, wb_before;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .st_done(st_done), .busy(busy)
`ifdef LSU_BOUNDS_CHECK_EN
    , .fault(fault)
`endif
  );
  assign mem_rdata = mem_read ? ram[mem_addr] : 8'h00;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_write) ram[mem_addr] = mem_wdata;
    end
  end
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if (wb_valid) wb_pulses++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic st, input logic [7:0] b, input logic [7:0] o, input logic [7:0] d, input logic [2:0] rd);
    req_valid = 1'b1;
    req_is_store = st;
    req_base = b;
    req_offset = o;
    req_wdata = d;
    req_rd = rd;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd", mem_read, 0);
    check("rst_wr", mem_write, 0);
    check("rst_wb", wb_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wbdata", wb_data, 0);
    req(1, 8'h04, 8'h03, 8'hA5, 3'd0);
    step();
    req_valid = 1'b0;
    check("st_wr", mem_write, 1);
    check("st_addr", mem_addr, 8'h07);
    check("st_wdata", mem_wdata, 8'hA5);
    check("st_done", st_done, 1);
    check("st_rd", mem_read, 0);
    check("st_busy", busy, 1);
    check("st_ready0", req_ready, 0);
    step();
    check("st_wr_off", mem_write, 0);
    check("st_done_off", st_done, 0);
    check("st_ready1", req_ready, 1);
    req(0, 8'h08, 8'hFF, 8'h00, 3'd3);
    step();
    req_valid = 1'b0;
    check("ld_rd", mem_read, 1);
    check("ld_addr", mem_addr, 8'h07);
    check("ld_wr", mem_write, 0);
    check("ld_wb0", wb_valid, 0);
    step();
    check("ld_wb", wb_valid, 1);
    check("ld_wbrd", wb_rd, 3);
    check("ld_wbdata", wb_data, 8'hA5);
    check("ld_rd_off", mem_read, 0);
    check("ld_ready0", req_ready, 0);
    step();
    check("ld_wb_off", wb_valid, 0);
    check("ld_ready1", req_ready, 1);
    check("ld_hold", wb_data, 8'hA5);
    req(1, 8'hFE, 8'h05, 8'h3C, 3'd0);
    step();
    req_valid = 1'b0;
    check("wrap_addr", mem_addr, 8'h03);
    check("wrap_wr", mem_write, 1);
    step();
    req(0, 8'h03, 8'h00, 8'h00, 3'd5);
    step();
    req(1, 8'h20, 8'h01, 8'h77, 3'd0);
    check("bp_rd", mem_read, 1);
    check("bp_addr0", mem_addr, 8'h03);
    step();
    check("bp_wb", wb_valid, 1);
    check("bp_wbdata", wb_data, 8'h3C);
    check("bp_wbrd", wb_rd, 5);
    check("bp_addr_hold", mem_addr, 8'h03);
    check("bp_wr0", mem_write, 0);
    step();
    check("bp_ready", req_ready, 1);
    check("bp_wr1", mem_write, 0);
    step();
    req_valid = 1'b0;
    check("bp_st_wr", mem_write, 1);
    check("bp_st_addr", mem_addr, 8'h21);
    check("bp_st_wdata", mem_wdata, 8'h77);
    step();
    check("no_overlap", overlap, 0);
    req(0, 8'h07, 8'h00, 8'h00, 3'd2);
    step();
    req_valid = 1'b0;
    check("abort_rd", mem_read, 1);
    wb_before = wb_pulses;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("abort_rd_off", mem_read, 0);
    check("abort_ready", req_ready, 1);
    check("abort_wbdata", wb_data, 0);
    step();
    step();
    check("abort_no_wb", wb_pulses, wb_before);
`ifdef LSU_BOUNDS_CHECK_EN
    req(0, 8'h10, 8'h00, 8'h00, 3'd1);
    step();
    req_valid = 1'b0;
    check("oob_fault", fault, 1);
    check("oob_rd", mem_read, 0);
    wb_before = wb_pulses;
    step();
    check("oob_fault_off", fault, 0);
    check("oob_ready", req_ready, 1);
    check("oob_no_wb", wb_pulses, wb_before);
    req(0, 8'h0F, 8'h00, 8'h00, 3'd1);
    step();
    req_valid = 1'b0;
    check("inb_fault", fault, 0);
    check("inb_rd", mem_read, 1);
    step();
    check("inb_wb", wb_valid, 1);
    check("inb_wbdata", wb_data, 8'h55);
    step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: the CPU-facing unit that drives mem_read/mem_write/addr/wdata toward the 8-bit data RAM and captures rdata.
- Accepts one load/store request from the decode/execute stage via valid/ready.
- Computes the effective address as base + signed offset.
- Performs the single-cycle RAM access, then returns load data to the register file as a one-cycle write-back pulse.

Parameters:
- DATA_W, 8, data width of register and memory words.
- ADDR_W, 8, memory address width.
- REG_IDX_W, 3, width of destination register index.
- MEM_DEPTH, 16, number of implemented RAM words; used only by the optional bounds check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- req_base  in  ADDR_W  base address (from register file).
- req_offset  in  ADDR_W  signed two's-complement offset.
- req_wdata  in  DATA_W  store data.
- req_rd  in  REG_IDX_W  load destination register.
- mem_read  out  1  read strobe to RAM.
- mem_write  out  1  write strobe to RAM.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; combinational while mem_read=1.
- wb_valid  out  1  one-cycle write-back pulse for loads.
- wb_rd  out  REG_IDX_W  write-back register index.
- wb_data  out  DATA_W  load result.
- st_done  out  1  one-cycle pulse when a store is issued.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active high. Sampled on a rising edge, it forces IDLE and clears every output/register to 0, except req_ready=1 after reset.
  - rst mid-operation aborts the transaction; no further mem_read/mem_write/wb_valid/st_done pulse is produced.
- Outputs: all registered except req_ready and busy, which decode the state register.
- FSM states: IDLE, ACCESS, WB.
- IDLE:
  - req_ready=1; memory strobes are 0.
  - On req_valid=1 at a rising edge:
    - latch kind, req_rd and req_wdata;
    - latch mem_addr = (req_base + req_offset) mod 2^ADDR_W (carry discarded, so 8'hFE + 8'h05 = 8'h03);
    - go to ACCESS.
  - Request inputs are ignored when req_valid=0.
- ACCESS, exactly one cycle, mem_addr stable:
  - Store: mem_write=1, mem_wdata=latched data, st_done=1; next state IDLE.
  - Load: mem_read=1; mem_rdata is sampled into wb_data at the end of the cycle; next state WB.
  - mem_read and mem_write are never both 1.
- WB, one cycle: wb_valid=1, wb_rd=latched index, wb_data held; next state IDLE.
- Latency, request accepted on edge N:
  - Store: mem_write high in cycle N+1; req_ready high again in cycle N+2.
  - Load: mem_read in N+1, wb_valid in N+2, req_ready in N+3.
- Throughput: one store per 2 cycles; one load per 3 cycles. No request is ever dropped; req_valid held while req_ready=0 simply waits.
- Hold values:
  - mem_addr, mem_wdata, wb_rd and wb_data hold their last values when idle.
  - Strobes and pulses are 0 outside the states above.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- When defined:
  - Add output port fault (1 bit, reset 0).
  - If the computed address is >= MEM_DEPTH, the unit goes to ACCESS but asserts neither mem_read nor mem_write nor st_done nor wb_valid.
  - Instead it pulses fault=1 in that cycle, then returns to IDLE.
- When undefined: no fault port; every address is passed to the RAM unchanged, and out-of-range behaviour is left to the RAM.

Test Plan:
- Reset: hold rst 2 cycles mid-load (in ACCESS) -> mem_read=0, wb_valid never pulses, req_ready=1, wb_data=0.
- Store: base=8'h04, offset=8'h03, wdata=8'hA5 -> next cycle mem_write=1, mem_addr=8'h07, mem_wdata=8'hA5, st_done=1 for exactly one cycle.
- Load-back: after the store above, load base=8'h08, offset=8'hFF (-1), rd=3, RAM model returns 8'hA5 at 8'h07 -> mem_read=1 at addr 8'h07, then wb_valid=1, wb_rd=3, wb_data=8'hA5.
- Wrap: base=8'hFE, offset=8'h05 -> mem_addr=8'h03.
- Backpressure: req_valid held high with back-to-back load then store -> second request accepted only when req_ready=1 (3 cycles after the first); strobes never overlap.
- With LSU_BOUNDS_CHECK_EN and MEM_DEPTH=16: load addr 8'h10 -> fault=1 one cycle, no mem_read, no wb_valid; addr 8'h0F -> normal load.
